// File: rtl/l1_hit_buffer_ctrl.sv
// l1_hit_buffer_ctrl
// Controller for the 512 x 1 pixel L1 hit buffer SRAM. Owns the circular write
// pointer and derives the L1-delayed read address from a programmable latency.
// On each L1A it issues a read, tags the returned hit, and queues the result
// in a small output FIFO with a valid/ready handshake toward the readout.
//
// Ports
//   clk        40 MHz bunch-crossing clock
//   reset      asynchronous active-low reset
//   enable     run control; low freezes the pointer, blocks writes and reads
//   l1Latency  L1 delay in clocks, latched while enable=0
//   L1A        level-1 accept pulse
//   wren       SRAM write enable (= enable)
//   wrAddr     SRAM write address (registered)
//   rden       SRAM read enable (= L1A & enable)
//   rdAddr     SRAM read address (wrAddr - latReg, mod 512)
//   outHit     SRAM read data, valid one clock after rden
//   evtValid   FIFO head valid
//   evtReady   consumer accepts the head entry
//   evtData    head entry {stale, hit, addr[8:0]}
//   primed     at least latReg cycles of history are held
//   ovfCnt     saturating dropped-event count (L1HIT_OVF_COUNTER_EN only)
//
// Optional feature macro: L1HIT_OVF_COUNTER_EN adds the ovfCnt port and counter.
module l1_hit_buffer_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MIN_LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [8:0]  l1Latency,
  input  logic        L1A,
  output logic        wren,
  output logic [8:0]  wrAddr,
  output logic        rden,
  output logic [8:0]  rdAddr,
  input  logic        outHit,
  output logic        evtValid,
  input  logic        evtReady,
  output logic [10:0] evtData,
  output logic        primed
`ifdef L1HIT_OVF_COUNTER_EN
  ,
  output logic [7:0]  ovfCnt
`endif
);

  localparam int unsigned AW = 9;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [AW-1:0] MIN_LAT_A = AW'(MIN_LAT);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic          stale;
    logic          hit;
    logic [AW-1:0] addr;
  } evt_t;

  logic [AW-1:0] latReg;
  logic [AW-1:0] lat_clamp;
  logic [AW-1:0] fillCnt;
  logic [AW-1:0] fill_nxt;

  // Latency register: tracks the clamped programmed value only while stopped.
  assign lat_clamp = (l1Latency < MIN_LAT_A) ? MIN_LAT_A : l1Latency;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       latReg <= MIN_LAT_A;
    else if (!enable) latReg <= lat_clamp;
  end

  // Write pointer and history fill level; stopping invalidates history.
  assign fill_nxt = (fillCnt < latReg) ? fillCnt + AW'(1) : fillCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrAddr  <= '0;
      fillCnt <= '0;
      primed  <= 1'b0;
    end else if (enable) begin
      wrAddr  <= wrAddr + AW'(1);
      fillCnt <= fill_nxt;
      primed  <= (fill_nxt == latReg);
    end else begin
      fillCnt <= '0;
      primed  <= 1'b0;
    end
  end

  assign wren   = enable;
  assign rden   = L1A & enable;
  assign rdAddr = wrAddr - latReg;

  // Read pipeline: holds the tag until the SRAM data returns.
  logic          pipe_vld;
  logic          pipe_stale;
  logic [AW-1:0] pipe_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld   <= 1'b0;
      pipe_stale <= 1'b0;
      pipe_addr  <= '0;
    end else begin
      pipe_vld <= rden;
      if (rden) begin
        pipe_stale <= !primed;
        pipe_addr  <= rdAddr;
      end
    end
  end

  evt_t push_entry;
  assign push_entry = '{stale: pipe_stale, hit: outHit & !pipe_stale, addr: pipe_addr};

  // Output event FIFO.
  evt_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          push;

  assign full     = (count == DEPTH_C);
  assign evtValid = (count != '0);
  assign evtData  = mem[rd_ptr];
  assign pop      = evtValid & evtReady;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = pipe_vld & (!full | pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

`ifdef L1HIT_OVF_COUNTER_EN
  // Saturating count of entries lost to a full FIFO.
  logic drop;
  assign drop = pipe_vld & full & !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         ovfCnt <= '0;
    else if (drop && ovfCnt != 8'hFF)   ovfCnt <= ovfCnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_l1_hit_buffer_ctrl.sv
// Testbench for l1_hit_buffer_ctrl: randomized stimulus against a transaction
// model (hit history by cycle, expected event queue, drop count).
module tb_l1_hit_buffer_ctrl;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned MIN_LAT    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [8:0]  l1Latency;
  logic        L1A;
  logic        wren;
  logic [8:0]  wrAddr;
  logic        rden;
  logic [8:0]  rdAddr;
  logic        outHit;
  logic        evtValid;
  logic        evtReady;
  logic [10:0] evtData;
  logic        primed;
  logic        hit_in;
`ifdef L1HIT_OVF_COUNTER_EN
  logic [7:0]  ovfCnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  l1_hit_buffer_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .MIN_LAT(MIN_LAT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .l1Latency(l1Latency), .L1A(L1A),
    .wren(wren), .wrAddr(wrAddr), .rden(rden), .rdAddr(rdAddr), .outHit(outHit),
    .evtValid(evtValid), .evtReady(evtReady), .evtData(evtData), .primed(primed)
`ifdef L1HIT_OVF_COUNTER_EN
    , .ovfCnt(ovfCnt)
`endif
  );

  // SRAM model: registered read, write on wren.
  logic sram [512];
  always @(posedge clk) begin
    if (rden) outHit <= sram[rdAddr];
    if (wren) sram[wrAddr] <= hit_in;
  end

  // Reference model state.
  int          gcyc;       // enabled cycles since reset (== expected wrAddr mod 512)
  int          run_start;  // gcyc at last enable rise
  int          lat_m;
  int          ovf_m;
  logic        hist [8192];
  logic [10:0] q [$];
  logic        pipe_v;
  logic [10:0] pipe_e;

  function automatic logic [10:0] exp_entry(input int g);
    logic st;
    logic h;
    st = (g - run_start) < lat_m;
    h  = st ? 1'b0 : hist[g - lat_m];
    return {st, h, 9'((g + 4096 - lat_m) % 512)};
  endfunction

  task automatic model_reset();
    q.delete();
    pipe_v    = 1'b0;
    gcyc      = 0;
    run_start = 0;
    ovf_m     = 0;
    lat_m     = MIN_LAT;
  endtask

  // Drive one cycle's inputs at the falling edge, settle, return.
  task automatic drive(input logic en, input logic hit, input logic l1a, input logic rdy);
    @(negedge clk);
    if (en && !enable) run_start = gcyc;
    enable   = en;
    hit_in   = hit;
    L1A      = l1a;
    evtReady = rdy;
    #1;
  endtask

  // Advance the model across the rising edge that ends the current cycle.
  task automatic model_edge();
    if (q.size() > 0 && evtReady) void'(q.pop_front());
    if (pipe_v) begin
      if (q.size() < FIFO_DEPTH) q.push_back(pipe_e);
      else if (ovf_m < 255) ovf_m++;
    end
    pipe_v = enable && L1A;
    if (pipe_v) pipe_e = exp_entry(gcyc);
    if (enable) begin
      hist[gcyc] = hit_in;
      gcyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; L1A = 1'b1; evtReady = 1'b0; hit_in = 1'b0;
    l1Latency = 9'd20;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (wrAddr !== 9'd0)    begin n_fail++; $display("FAIL reset_wrAddr got %0d want 0", wrAddr); end
    n_cmp++; if (rdAddr !== 9'd510)  begin n_fail++; $display("FAIL reset_rdAddr got %0d want 510", rdAddr); end
    n_cmp++; if (evtValid !== 1'b0)  begin n_fail++; $display("FAIL reset_evtValid got %b want 0", evtValid); end
    n_cmp++; if (evtData !== 11'd0)  begin n_fail++; $display("FAIL reset_evtData got %h want 0", evtData); end
    n_cmp++; if (primed !== 1'b0)    begin n_fail++; $display("FAIL reset_primed got %b want 0", primed); end
    n_cmp++; if (rden !== 1'b0)      begin n_fail++; $display("FAIL reset_rden got %b want 0", rden); end
    n_cmp++; if (wren !== 1'b0)      begin n_fail++; $display("FAIL reset_wren got %b want 0", wren); end
`ifdef L1HIT_OVF_COUNTER_EN
    n_cmp++; if (ovfCnt !== 8'd0)    begin n_fail++; $display("FAIL reset_ovfCnt got %0d want 0", ovfCnt); end
`endif
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    model_edge();
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (rdAddr !== 9'd492)  begin n_fail++; $display("FAIL latch_rdAddr got %0d want 492", rdAddr); end
    n_cmp++; if (rden !== 1'b0)      begin n_fail++; $display("FAIL disabled_rden got %b want 0", rden); end
    model_edge();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (evtValid !== 1'b0)  begin n_fail++; $display("FAIL disabled_l1a_evtValid got %b want 0", evtValid); end
    model_edge();
  endtask

  // Reprogram latency while stopped, then stream with random hits and L1As.
  task automatic test_stream(input int prog, input int ncyc);
    logic hit;
    logic l1a;
    logic exp_p;
    l1Latency = 9'(prog);
    repeat (3) begin drive(1'b0, 1'b0, 1'b0, 1'b1); model_edge(); end
    lat_m = (prog < MIN_LAT) ? MIN_LAT : prog;
    for (int n = 0; n < ncyc + 2; n++) begin
      hit = (n == 10) ? 1'b1 : ($urandom_range(0, 2) == 0);
      l1a = (n < ncyc) && (($urandom_range(0, 5) == 0) || n == 12 || n == 100 ||
                           n == lat_m || n == lat_m - 1 || (gcyc % 512) == 5);
      drive(1'b1, hit, l1a, 1'b1);
      l1Latency = 9'($urandom);
      exp_p = (gcyc - run_start) >= lat_m;
      n_cmp++; if (wrAddr !== 9'(gcyc % 512)) begin n_fail++; $display("FAIL stream_wrAddr lat=%0d n=%0d got %0d want %0d", lat_m, n, wrAddr, gcyc % 512); end
      n_cmp++; if (rdAddr !== 9'((gcyc + 4096 - lat_m) % 512)) begin n_fail++; $display("FAIL stream_rdAddr lat=%0d n=%0d got %0d want %0d", lat_m, n, rdAddr, (gcyc + 4096 - lat_m) % 512); end
      n_cmp++; if (primed !== exp_p) begin n_fail++; $display("FAIL stream_primed lat=%0d n=%0d got %b want %b", lat_m, n, primed, exp_p); end
      n_cmp++; if (rden !== l1a || wren !== 1'b1) begin n_fail++; $display("FAIL stream_rden_wren lat=%0d n=%0d got %b%b want %b1", lat_m, n, rden, wren, l1a); end
      n_cmp++; if (evtValid !== (q.size() > 0)) begin n_fail++; $display("FAIL stream_evtValid lat=%0d n=%0d got %b want %b", lat_m, n, evtValid, q.size() > 0); end
      if (q.size() > 0) begin
        n_cmp++; if (evtData !== q[0]) begin n_fail++; $display("FAIL stream_evtData lat=%0d n=%0d got %h want %h", lat_m, n, evtData, q[0]); end
      end
      if ((gcyc % 512) == 5 && lat_m == 20) begin
        n_cmp++; if (rdAddr !== 9'd497) begin n_fail++; $display("FAIL wrap_rdAddr got %0d want 497", rdAddr); end
      end
      model_edge();
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] held;
    int ovf_start;
    int drained;
    repeat (3) begin drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1); model_edge(); end
    ovf_start = ovf_m;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      n_cmp++; if (evtValid !== (q.size() > 0)) begin n_fail++; $display("FAIL bp_fill_evtValid i=%0d got %b want %b", i, evtValid, q.size() > 0); end
      model_edge();
    end
    held = q[0];
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      n_cmp++; if (evtValid !== 1'b1 || evtData !== held) begin n_fail++; $display("FAIL bp_hold i=%0d got %b/%h want 1/%h", i, evtValid, evtData, held); end
      model_edge();
    end
`ifdef L1HIT_OVF_COUNTER_EN
    n_cmp++; if (ovfCnt !== 8'(ovf_start + 2)) begin n_fail++; $display("FAIL bp_ovfCnt got %0d want %0d", ovfCnt, ovf_start + 2); end
`endif
    drained = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      drained += int'(evtValid);
      n_cmp++; if (evtValid !== (q.size() > 0)) begin n_fail++; $display("FAIL bp_drain_evtValid i=%0d got %b want %b", i, evtValid, q.size() > 0); end
      if (q.size() > 0) begin
        n_cmp++; if (evtData !== q[0]) begin n_fail++; $display("FAIL bp_drain_evtData i=%0d got %h want %h", i, evtData, q[0]); end
      end
      model_edge();
    end
    n_cmp++; if (drained !== 4) begin n_fail++; $display("FAIL bp_drained got %0d want 4", drained); end
  endtask

  task automatic test_random_handshake();
    logic l1a;
    for (int i = 0; i < 300; i++) begin
      l1a = 1'($urandom_range(0, 1));
      drive(1'b1, 1'($urandom_range(0, 1)), l1a, (i >= 290) ? 1'b1 : 1'($urandom_range(0, 1)));
      n_cmp++; if (rden !== l1a) begin n_fail++; $display("FAIL hs_rden i=%0d got %b want %b", i, rden, l1a); end
      n_cmp++; if (evtValid !== (q.size() > 0)) begin n_fail++; $display("FAIL hs_evtValid i=%0d got %b want %b", i, evtValid, q.size() > 0); end
      if (q.size() > 0) begin
        n_cmp++; if (evtData !== q[0]) begin n_fail++; $display("FAIL hs_evtData i=%0d got %h want %h", i, evtData, q[0]); end
      end
`ifdef L1HIT_OVF_COUNTER_EN
      n_cmp++; if (ovfCnt !== 8'(ovf_m)) begin n_fail++; $display("FAIL hs_ovfCnt i=%0d got %0d want %0d", i, ovfCnt, ovf_m); end
`endif
      model_edge();
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 1'b1, 1'b0); model_edge(); end
    drive(1'b1, 1'b0, 1'b0, 1'b0); model_edge();
    drive(1'b1, 1'b0, 1'b1, 1'b0); model_edge();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (evtValid !== 1'b1 || primed !== 1'b1) begin n_fail++; $display("FAIL mid_pre_state got %b/%b want 1/1", evtValid, primed); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (evtValid !== 1'b0) begin n_fail++; $display("FAIL mid_evtValid got %b want 0", evtValid); end
    n_cmp++; if (wrAddr !== 9'd0)   begin n_fail++; $display("FAIL mid_wrAddr got %0d want 0", wrAddr); end
    n_cmp++; if (primed !== 1'b0)   begin n_fail++; $display("FAIL mid_primed got %b want 0", primed); end
`ifdef L1HIT_OVF_COUNTER_EN
    n_cmp++; if (ovfCnt !== 8'd0)   begin n_fail++; $display("FAIL mid_ovfCnt got %0d want 0", ovfCnt); end
`endif
    repeat (2) @(negedge clk);
    enable = 1'b0; L1A = 1'b0;
    reset = 1'b1;
    l1Latency = 9'd20;
    lat_m = 20;
    for (int i = 0; i < 10; i++) begin
      drive((i >= 2), 1'b0, 1'b0, 1'b0);
      n_cmp++; if (evtValid !== 1'b0) begin n_fail++; $display("FAIL post_reset_evtValid i=%0d got %b want 0", i, evtValid); end
      n_cmp++; if (wrAddr !== 9'(gcyc % 512)) begin n_fail++; $display("FAIL post_reset_wrAddr i=%0d got %0d want %0d", i, wrAddr, gcyc % 512); end
      model_edge();
    end
  endtask

  initial begin
    test_reset();
    test_stream(501, 1100);
    test_stream(0, 40);
    test_stream(1, 40);
    test_stream(20, 600);
    test_backpressure();
    test_random_handshake();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
